// File: rtl/ahb_sram_bridge_pkg.sv
// Shared encodings, write-request payload and lane/alignment helpers for ahb_sram_bridge.
// The alignment check is only used when AHB_SRAM_BRIDGE_ERR_EN is defined.
package ahb_sram_bridge_pkg;

  localparam int unsigned AW  = 16;
  localparam int unsigned WAW = AW - 2;
  localparam int unsigned DW  = 32;
  localparam int unsigned NB  = DW / 8;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    ST_OKAY = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } err_state_e;

  typedef struct packed {
    logic [WAW-1:0] addr;
    logic [NB-1:0]  mask;
  } wreq_t;

  // Byte lanes touched by a transfer; oversized or misaligned sizes fall back to the container.
  function automatic logic [NB-1:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
    lane_mask = '1;
    case (size)
      HSIZE_BYTE: lane_mask = NB'(1) << a;
      HSIZE_HALF: lane_mask = a[1] ? 4'b1100 : 4'b0011;
      default:    lane_mask = '1;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] size, input logic [1:0] a);
    case (size)
      HSIZE_BYTE: misaligned = 1'b0;
      HSIZE_HALF: misaligned = a[0];
      HSIZE_WORD: misaligned = (a != 2'b00);
      default:    misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ahb_sram_wbuf.sv
// One-entry write buffer: holds a deferred write, decides when it may use the SRAM,
// and overlays its bytes onto SRAM read data so reads see the latest write.
module ahb_sram_wbuf
  import ahb_sram_bridge_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_wr_req,
  input  wreq_t          i_wreq,
  input  logic           i_rd_aphase,
  input  logic [DW-1:0]  i_wdata,
  input  logic [WAW-1:0] i_rd_addr,
  input  logic [DW-1:0]  i_sram_rdata,
  output logic           o_commit_c,
  output wreq_t          o_cmt_req_c,
  output logic [DW-1:0]  o_cmt_data_c,
  output logic [DW-1:0]  o_rdata_c
);

  logic          r_pend;
  logic          r_full;
  wreq_t         r_req;
  logic [DW-1:0] r_data;
  logic          w_wr_dphase;
  logic          w_hit;

  // Pending but not yet captured means HWDATA carries this write right now.
  assign w_wr_dphase  = r_pend & ~r_full;
  assign o_commit_c   = rst_n & r_pend & ~i_rd_aphase;
  assign o_cmt_req_c  = r_req;
  assign o_cmt_data_c = r_full ? r_data : i_wdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend <= 1'b0;
      r_full <= 1'b0;
      r_req  <= '0;
      r_data <= '0;
    end else begin
      if (w_wr_dphase && !o_commit_c) begin
        r_data <= i_wdata;
        r_full <= 1'b1;
      end
      if (o_commit_c) begin
        r_pend <= 1'b0;
        r_full <= 1'b0;
      end
      if (i_wr_req) begin
        r_req  <= i_wreq;
        r_pend <= 1'b1;
        r_full <= 1'b0;
      end
    end
  end

  assign w_hit = r_full && (r_req.addr == i_rd_addr);

  always_comb begin
    o_rdata_c = i_sram_rdata;
    for (int unsigned i = 0; i < NB; i++) begin
      if (w_hit && r_req.mask[i]) o_rdata_c[8*i +: 8] = r_data[8*i +: 8];
    end
  end

endmodule

// File: rtl/ahb_sram_bridge.sv
// AHB-Lite to single-port SRAM bridge with zero wait states and a one-entry write buffer.
// Define AHB_SRAM_BRIDGE_ERR_EN to reject misaligned transfers with a two-cycle ERROR response.
module ahb_sram_bridge
  import ahb_sram_bridge_pkg::*;
(
  input  logic           HCLK,
  input  logic           HRESETn,
  input  logic           HSEL,
  input  logic           HREADY,
  input  logic [1:0]     HTRANS,
  input  logic [2:0]     HSIZE,
  input  logic           HWRITE,
  input  logic [AW-1:0]  HADDR,
  input  logic [DW-1:0]  HWDATA,
  output logic           HREADYOUT,
  output logic           HRESP,
  output logic [DW-1:0]  HRDATA,
  input  logic [DW-1:0]  SRAMRDATA,
  output logic [WAW-1:0] SRAMADDR,
  output logic [DW-1:0]  SRAMWDATA,
  output logic [NB-1:0]  SRAMWEN,
  output logic           SRAMCS
);

  logic           w_acc;
  logic           w_mis;
  logic           w_xfer;
  logic           w_rd_aphase;
  logic           w_wr_aphase;
  logic           w_commit;
  wreq_t          w_wreq;
  wreq_t          w_cmt_req;
  logic [DW-1:0]  w_cmt_data;
  logic [DW-1:0]  w_merged;
  logic           r_rd_dphase;
  logic [WAW-1:0] r_rd_addr;
  logic           w_unused;

  assign w_unused = HTRANS[0];
  assign w_acc    = HRESETn & HSEL & HREADY & HTRANS[1];

`ifdef AHB_SRAM_BRIDGE_ERR_EN
  assign w_mis = misaligned(HSIZE, HADDR[1:0]);
`else
  assign w_mis = 1'b0;
`endif

  assign w_xfer      = w_acc & ~w_mis;
  assign w_rd_aphase = w_xfer & ~HWRITE;
  assign w_wr_aphase = w_xfer & HWRITE;
  assign w_wreq      = '{addr: HADDR[AW-1:2], mask: lane_mask(HSIZE, HADDR[1:0])};

  ahb_sram_wbuf u_wbuf (
    .clk          (HCLK),
    .rst_n        (HRESETn),
    .i_wr_req     (w_wr_aphase),
    .i_wreq       (w_wreq),
    .i_rd_aphase  (w_rd_aphase),
    .i_wdata      (HWDATA),
    .i_rd_addr    (r_rd_addr),
    .i_sram_rdata (SRAMRDATA),
    .o_commit_c   (w_commit),
    .o_cmt_req_c  (w_cmt_req),
    .o_cmt_data_c (w_cmt_data),
    .o_rdata_c    (w_merged)
  );

  // Reads own the SRAM port; the buffered write takes any other cycle.
  always_comb begin
    SRAMCS    = 1'b0;
    SRAMADDR  = '0;
    SRAMWEN   = '0;
    SRAMWDATA = '0;
    if (w_rd_aphase) begin
      SRAMCS   = 1'b1;
      SRAMADDR = HADDR[AW-1:2];
    end else if (w_commit) begin
      SRAMCS    = 1'b1;
      SRAMADDR  = w_cmt_req.addr;
      SRAMWEN   = w_cmt_req.mask;
      SRAMWDATA = w_cmt_data;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_rd_dphase <= 1'b0;
      r_rd_addr   <= '0;
    end else begin
      r_rd_dphase <= w_rd_aphase;
      if (w_rd_aphase) r_rd_addr <= HADDR[AW-1:2];
    end
  end

  assign HRDATA = (HRESETn && r_rd_dphase) ? w_merged : '0;

`ifdef AHB_SRAM_BRIDGE_ERR_EN
  err_state_e r_state;
  err_state_e w_state_nxt;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) r_state <= ST_OKAY;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_OKAY: if (w_acc && w_mis) w_state_nxt = ST_ERR1;
      ST_ERR1: w_state_nxt = ST_ERR2;
      ST_ERR2: w_state_nxt = (w_acc && w_mis) ? ST_ERR1 : ST_OKAY;
      default: w_state_nxt = ST_OKAY;
    endcase
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (r_state)
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      ST_ERR2: HRESP = 1'b1;
      default: HRESP = 1'b0;
    endcase
  end
`else
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_sram_bridge.sv
// Scoreboard bench for ahb_sram_bridge: directed scenarios plus random AHB traffic
// checked against an architectural byte-addressed memory model and a behavioural SRAM.
module tb_ahb_sram_bridge;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic        HREADY;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [15:0] HADDR;
  logic [31:0] HWDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic [31:0] SRAMRDATA;
  logic [13:0] SRAMADDR;
  logic [31:0] SRAMWDATA;
  logic [3:0]  SRAMWEN;
  logic        SRAMCS;

  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] sram_mem [0:16383];
  logic [31:0] model    [0:63];
  logic [31:0] exp_q    [$];
  logic [31:0] mon_exp;
  bit          prev_rd  = 1'b0;
  bit          chk_ready = 1'b1;
  bit          nxt_wd_v = 1'b0;
  logic [31:0] nxt_wd;
  logic [31:0] saved;

  always #5 HCLK = ~HCLK;
  assign HREADY = HREADYOUT;

  ahb_sram_bridge dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADY), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HWRITE(HWRITE), .HADDR(HADDR), .HWDATA(HWDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .SRAMRDATA(SRAMRDATA),
    .SRAMADDR(SRAMADDR), .SRAMWDATA(SRAMWDATA), .SRAMWEN(SRAMWEN), .SRAMCS(SRAMCS)
  );

  // Block RAM: registered read, byte write enables, zero output when deselected.
  always @(posedge HCLK) begin
    if (SRAMCS) begin
      for (int b = 0; b < 4; b++)
        if (SRAMWEN[b]) sram_mem[SRAMADDR][8*b +: 8] <= SRAMWDATA[8*b +: 8];
      SRAMRDATA <= sram_mem[SRAMADDR];
    end else begin
      SRAMRDATA <= '0;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_write(input logic [15:0] a, input logic [2:0] sz, input logic [31:0] d);
    int nbytes;
    int start;
    logic [31:0] w;
    nbytes = (sz >= 3'd2) ? 4 : (1 << sz);
    start  = int'(a[1:0]) / nbytes * nbytes;
    w      = model[a[7:2]];
    for (int b = start; b < start + nbytes; b++) w[8*b +: 8] = d[8*b +: 8];
    model[a[7:2]] = w;
  endtask

  function automatic bit tb_misaligned(input logic [2:0] sz, input logic [15:0] a);
    if (sz > 3'd2) return 1'b1;
    return (int'(a[1:0]) % (1 << sz)) != 0;
  endfunction

  // One bus cycle: new address phase plus the data of the previous accepted write.
  task automatic step(input bit sel, input logic [1:0] tr, input bit wr,
                      input logic [2:0] sz, input logic [15:0] a, input logic [31:0] wd);
    bit acc;
    bit mis;
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    HWDATA  = nxt_wd_v ? nxt_wd : 32'($urandom);
    HSEL = sel; HTRANS = tr; HWRITE = wr; HSIZE = sz; HADDR = a;
    acc = sel && tr[1] && HREADY;
    mis = 1'b0;
`ifdef AHB_SRAM_BRIDGE_ERR_EN
    mis = tb_misaligned(sz, a);
`endif
    nxt_wd_v = 1'b0;
    if (acc && !mis) begin
      if (wr) begin
        model_write(a, sz, wd);
        nxt_wd_v = 1'b1;
        nxt_wd   = wd;
      end else begin
        exp_q.push_back(model[a[7:2]]);
      end
    end
  endtask

  task automatic idle();
    step(1'b1, 2'b00, 1'b0, 3'd0, 16'h0, 32'h0);
  endtask

  task automatic wr(input logic [15:0] a, input logic [2:0] sz, input logic [31:0] d);
    step(1'b1, 2'b10, 1'b1, sz, a, d);
  endtask

  task automatic rd(input logic [15:0] a);
    step(1'b1, 2'b10, 1'b0, 3'd2, a, 32'h0);
  endtask

  task automatic rst_cycle();
    @(posedge HCLK); #1;
    HRESETn = 1'b0; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    HSIZE = 3'd0; HADDR = 16'h0; HWDATA = 32'($urandom);
    nxt_wd_v = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_ctl"}, {HREADYOUT, HRESP, SRAMCS, SRAMWEN, SRAMADDR}, {1'b1, 1'b0, 1'b0, 4'h0, 14'h0});
    chk({nm, "_hrdata"}, HRDATA, 32'h0);
    chk({nm, "_wdata"}, SRAMWDATA, 32'h0);
  endtask

  // Monitor: pops the expected word in each read data phase; HRDATA must be zero otherwise.
  always @(negedge HCLK) begin
    if (!HRESETn) begin
      exp_q.delete();
      prev_rd = 1'b0;
    end else begin
      if (prev_rd) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL hrdata: no expected value queued, got 0x%08h at %0t", HRDATA, $time);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("hrdata", HRDATA, mon_exp);
        end
      end else begin
        chk("hrdata_zero", HRDATA, 32'h0);
      end
      if (chk_ready) chk("ready_okay", {HREADYOUT, HRESP}, 2'b10);
      if (HSEL && HREADY && HTRANS[1] && !HWRITE)
        chk("rd_aphase", {SRAMCS, SRAMWEN, SRAMADDR}, {1'b1, 4'h0, HADDR[15:2]});
      prev_rd = HSEL && HREADY && HTRANS[1] && !HWRITE;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16384; i++) sram_mem[i] = 32'h0;
    for (int i = 0; i < 64; i++) model[i] = 32'h0;
    HRESETn = 1'b0; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    HSIZE = 3'd0; HADDR = 16'h0; HWDATA = 32'h0;

    rst_cycle();
    rst_cycle();
    @(negedge HCLK);
    chk_reset_outputs("reset");

    // Word write commits in its data phase when the bus is idle.
    wr(16'h0010, 3'd2, 32'hDEADBEEF);
    idle();
    @(negedge HCLK);
    chk("t1_commit", {SRAMCS, SRAMWEN, SRAMADDR}, {1'b1, 4'hF, 14'h004});
    chk("t1_wdata", SRAMWDATA, 32'hDEADBEEF);
    rd(16'h0010);
    idle();

    // Byte write followed by a read of the same word: merged data, commit after the read.
    wr(16'h0010, 3'd2, 32'h11223344);
    idle();
    wr(16'h0013, 3'd0, 32'hAA000000);
    rd(16'h0010);
    idle();
    @(negedge HCLK);
    chk("t2_merge", HRDATA, 32'hAA223344);
    chk("t2_commit", {SRAMCS, SRAMWEN, SRAMADDR}, {1'b1, 4'h8, 14'h004});
    chk("t2_wbyte", SRAMWDATA[31:24], 8'hAA);

    // Write held off by a run of five reads.
    wr(16'h0020, 3'd2, 32'h0BADF00D);
    rd(16'h0020); rd(16'h0024); rd(16'h0010); rd(16'h0020); rd(16'h0000);
    idle();
    @(negedge HCLK);
    chk("t3_commit", {SRAMCS, SRAMWEN, SRAMADDR}, {1'b1, 4'hF, 14'h008});
    chk("t3_wdata", SRAMWDATA, 32'h0BADF00D);

    // Back-to-back writes each commit in the next write's address phase.
    wr(16'h0000, 3'd2, 32'hA0A0A0A0);
    wr(16'h0004, 3'd2, 32'hB1B1B1B1);
    @(negedge HCLK);
    chk("t4_c0", {SRAMCS, SRAMWEN, SRAMADDR, SRAMWDATA}, {1'b1, 4'hF, 14'h000, 32'hA0A0A0A0});
    wr(16'h0008, 3'd2, 32'hC2C2C2C2);
    @(negedge HCLK);
    chk("t4_c1", {SRAMCS, SRAMWEN, SRAMADDR, SRAMWDATA}, {1'b1, 4'hF, 14'h001, 32'hB1B1B1B1});
    idle();
    @(negedge HCLK);
    chk("t4_c2", {SRAMCS, SRAMWEN, SRAMADDR, SRAMWDATA}, {1'b1, 4'hF, 14'h002, 32'hC2C2C2C2});
    rd(16'h0000); rd(16'h0004); rd(16'h0008);
    idle();

    // Misaligned halfword at 0x01.
`ifdef AHB_SRAM_BRIDGE_ERR_EN
    chk_ready = 1'b0;
    wr(16'h0001, 3'd1, 32'hCAFEBEEF);
    idle();
    @(negedge HCLK);
    chk("t5_err1", {HREADYOUT, HRESP, SRAMCS}, 3'b010);
    idle();
    @(negedge HCLK);
    chk("t5_err2", {HREADYOUT, HRESP, SRAMCS}, 3'b110);
    idle();
    @(negedge HCLK);
    chk("t5_okay", {HREADYOUT, HRESP, SRAMCS}, 3'b100);
    chk_ready = 1'b1;
`else
    wr(16'h0001, 3'd1, 32'hCAFEBEEF);
    idle();
    @(negedge HCLK);
    chk("t5_lanes", {SRAMCS, SRAMWEN, SRAMADDR}, {1'b1, 4'h3, 14'h000});
    chk("t5_wdata", SRAMWDATA[15:0], 16'hBEEF);
`endif
    rd(16'h0000);
    idle();

    // Reset with a write captured in the buffer discards it.
    saved = model[16];
    wr(16'h0040, 3'd2, 32'h5A5A0001);
    rd(16'h0080);
    rst_cycle();
    @(negedge HCLK);
    chk("t6_rst_wen", SRAMWEN, 4'h0);
    model[16] = saved;
    idle();
    @(negedge HCLK);
    chk_reset_outputs("t6_after");
    idle();
    @(negedge HCLK);
    chk("t6_no_commit", SRAMWEN, 4'h0);
    rd(16'h0040);
    idle();

    // Random traffic against the architectural model.
    for (int n = 0; n < 500; n++) begin
      int unsigned r;
      logic [2:0]  sz;
      logic [15:0] a;
      r  = $urandom_range(0, 99);
      sz = 3'($urandom_range(0, 2));
      a  = 16'($urandom_range(0, 255));
      a  = a & ~16'((1 << sz) - 1);
      if (r < 20)      step(1'b1, 2'($urandom_range(0, 1)), 1'($urandom), sz, a, 32'h0);
      else if (r < 25) step(1'b0, 2'($urandom_range(2, 3)), 1'($urandom), sz, a, 32'h0);
      else if (r < 60) step(1'b1, 2'($urandom_range(2, 3)), 1'b1, sz, a, 32'($urandom));
      else             step(1'b1, 2'($urandom_range(2, 3)), 1'b0, sz, a, 32'h0);
    end
    idle(); idle(); idle();
    @(negedge HCLK);

    for (int w = 0; w < 64; w++) chk($sformatf("mem[%0d]", w), sram_mem[w], model[w]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ahb_sram_bridge.md
# ahb_sram_bridge

AHB-Lite slave that fronts the on-chip FPGA block-RAM SRAM (one-cycle registered read, per-byte write enables, read data forced to zero when the SRAM chip select was low). It converts AHB address/data-phase transfers into SRAM accesses with zero wait states for both reads and writes. A one-entry write buffer defers each write until a cycle with no SRAM read, and read data is byte-merged with the pending write so the bus always returns coherent data.

## Interface
- AW, 16, byte address width; SRAM word address is AW-2 bits

- HCLK  in  1  system clock
- HRESETn  in  1  reset, synchronous, active-low
- HSEL  in  1  slave select
- HREADY  in  1  bus ready; transfer accepted only when high
- HTRANS  in  2  transfer type; HTRANS[1]=1 means NONSEQ/SEQ
- HSIZE  in  3  0=byte, 1=halfword, 2=word
- HWRITE  in  1  1=write
- HADDR  in  AW  byte address
- HWDATA  in  32  write data, valid in the data phase
- HREADYOUT  out  1  slave ready
- HRESP  out  1  1=ERROR
- HRDATA  out  32  read data
- SRAMRDATA  in  32  SRAM read data, one cycle after SRAMCS
- SRAMADDR  out  AW-2  SRAM word address
- SRAMWDATA  out  32  SRAM write data
- SRAMWEN  out  4  byte write enables
- SRAMCS  out  1  SRAM chip select

## Operation
- Accept: HSEL & HREADY & HTRANS[1]. Lane mask comes from HSIZE/HADDR[1:0] (byte: 1<<a, half: 0011/1100, word: 1111).
- Read address phase: SRAMCS=1, SRAMADDR=HADDR[AW-1:2], SRAMWEN=0. Set rd_dphase and latch the word address.
- Read data phase: for each byte i, HRDATA[i] = buf_data[i] if buf_full & buf_addr==rd_addr & buf_mask[i], otherwise SRAMRDATA[i]. HRDATA=0 in all other cycles.
- Write address phase: latch buf_addr and buf_mask, set buf_pend. Data phase: HWDATA is the write data. buf_data <= HWDATA and buf_full=1 unless committed the same cycle.
- Commit: a write is committed in any cycle with a pending write whose data is available and no accepted read address phase. Outputs: SRAMCS=1, SRAMADDR=buf_addr, SRAMWEN=buf_mask. SRAMWDATA = HWDATA if this is the write's data phase, else buf_data. Commit clears buf_pend/buf_full unless a new write address phase reloads them in the same cycle.
- Back-to-back writes: W1 commits in W2's address phase using HWDATA directly.
- Write then read: write data is captured into buf_data. Commit is deferred through any run of read address phases.
- Reads and writes never stall; HREADYOUT=1 outside error handling.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, SRAMCS=0, SRAMWEN=0, SRAMADDR=0, SRAMWDATA=0. All buffer flags and the FSM are cleared.
- Reset asserted with a write pending: the write is discarded and SRAM is not written.
- Read latency: HRDATA is valid in the cycle after the accepted address phase.
- Write commit latency: 1 cycle minimum, unbounded while reads continue. The buffer never overflows, because a new write address phase is always a commit opportunity.
- Read address phase and commit never coincide; the read wins.
- Idle cycles (HTRANS=IDLE/BUSY or HSEL=0) commit a full buffer.

## Configuration
- AHB_SRAM_BRIDGE_ERR_EN defined: a transfer is misaligned if it is a halfword with HADDR[0]=1, a word with HADDR[1:0]≠0, or HSIZE>2. A misaligned transfer is accepted but makes no SRAM access and no buffer update.
  - FSM states: OKAY → ERR1 (HREADYOUT=0, HRESP=1) → ERR2 (HREADYOUT=1, HRESP=1) → OKAY.
  - A pending write may commit during ERR1/ERR2.
- Macro undefined: no alignment check, HRESP tied to 0, no FSM. Misaligned transfers use the lane mask of the aligned container; HSIZE>2 is treated as a word.

## Structure
- Package ahb_sram_bridge_pkg holds:
  - HTRANS and HSIZE encodings.
  - FSM state enum (OKAY/ERR1/ERR2).
  - Lane-mask function (HSIZE, addr[1:0]) → 4-bit mask.
  - Misalignment predicate.
- Sub-module ahb_sram_wbuf holds buf_addr/buf_mask/buf_data/buf_pend/buf_full, the commit decision and the byte merge. The top level holds AHB phase decode, the SRAM output mux and the error FSM.

## Test plan
- Word write 0x0000_0010 ← 0xDEADBEEF, then idle. Required: commit in the data-phase cycle with SRAMWEN=1111 and SRAMADDR=0x004. A later read returns 0xDEADBEEF.
- Byte write 0x13 ← 0xAA (HWDATA[31:24]) immediately followed by a word read of 0x10 on SRAM data 0x11223344. Required: HRDATA=0xAA223344, and the commit occurs after the read.
- Write to 0x20 followed by five consecutive reads. Required: no commit during the reads, commit in the first non-read cycle, SRAMWEN not asserted in any read cycle.
- Back-to-back word writes to 0x00, 0x04, 0x08. Required: each commits in the next write's address phase, HREADYOUT stays 1 throughout, and a final readback matches.
- With AHB_SRAM_BRIDGE_ERR_EN, halfword at 0x01. Required: HREADYOUT/HRESP = 0/1 then 1/1, SRAMCS=0, memory unchanged. Without the macro, the same transfer writes lanes 0011.
- HRESETn low for one cycle while a write is buffered. Required: all outputs reach their reset values next cycle, SRAMWEN never asserts for that write, and the memory is unchanged.
